// File: rtl/phy_rx_link_ctrl_pkg.sv
// Shared definitions for the 2-lane PHY RX link-training controller:
// FSM state encoding, default qualification limits and a counter-width helper.
package phy_rx_link_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_WAIT_FIRST  = 3'd1,
    ST_WAIT_SECOND = 3'd2,
    ST_LINK_UP     = 3'd3,
    ST_RECOVER     = 3'd4
  } link_state_e;

  localparam int unsigned TIMEOUT_CYCLES_DEF = 64;
  localparam int unsigned MAX_SKEW_DEF       = 4;
  localparam int unsigned LOSS_LIMIT_DEF     = 3;
  localparam int unsigned RETRAIN_WIDTH      = 4;

  // Bits needed to hold values 0..max_val (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/phy_rx_link_ctrl_lane_loss_mon.sv
// Per-lane loss monitor: counts consecutive cycles a lane is inactive while the
// link is up and flags the cycle on which that run reaches LOSS_LIMIT.
module lane_loss_mon
  import phy_rx_link_ctrl_pkg::*;
#(
  parameter int unsigned LOSS_LIMIT = LOSS_LIMIT_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  input  logic active_i,
  output logic loss_o
);

  localparam int unsigned CW = cnt_width(LOSS_LIMIT);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: cleared by lane activity or when not monitoring, saturates at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (!run_i || active_i) begin
      cnt_d = '0;
    end else if (cnt_q != CW'(LOSS_LIMIT)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Consecutive-inactive counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Flags the sample that brings the inactive run up to LOSS_LIMIT cycles.
  assign loss_o = run_i && !active_i && (cnt_q >= CW'(LOSS_LIMIT - 1));

endmodule

// File: rtl/phy_rx_link_ctrl.sv
// Link-training controller for the 2-lane PHY RX path: waits for both lane
// aligners to lock, measures inter-lane skew, qualifies the link and retrains
// on lane loss, excessive skew or first-lane timeout. All outputs registered.
module phy_rx_link_ctrl
  import phy_rx_link_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int unsigned MAX_SKEW       = MAX_SKEW_DEF,
  parameter int unsigned LOSS_LIMIT     = LOSS_LIMIT_DEF
) (
  input  logic       clk_4f,
  input  logic       reset,
  input  logic       enable,
  input  logic       active_0,
  input  logic       active_1,
  output logic       link_up,
  output logic [1:0] lane_en,
  output logic       skew_lane,
  output logic [2:0] skew_cycles,
  output logic       timeout_err,
  output logic [3:0] retrain_cnt,
  output logic [2:0] state
);

  localparam int unsigned TW = cnt_width(TIMEOUT_CYCLES - 1);
  localparam int unsigned SW = cnt_width(MAX_SKEW);

  link_state_e              state_q, state_d;
  logic [TW-1:0]            tmo_cnt_q, tmo_cnt_d;
  logic [SW-1:0]            skew_cnt_q, skew_cnt_d;
  logic                     lag_lane_q, lag_lane_d;
  logic                     link_up_q, link_up_d;
  logic [1:0]               lane_en_q, lane_en_d;
  logic                     skew_lane_q, skew_lane_d;
  logic [2:0]               skew_cycles_q, skew_cycles_d;
  logic                     timeout_q, timeout_d;
  logic [RETRAIN_WIDTH-1:0] retrain_q, retrain_d;

  logic loss_0, loss_1;
  logic lead_act, lag_act;
  logic link_run;

  assign link_run = (state_q == ST_LINK_UP);

  lane_loss_mon #(.LOSS_LIMIT(LOSS_LIMIT)) u_loss_0 (
    .clk_i    (clk_4f),
    .rst_i    (reset),
    .run_i    (link_run),
    .active_i (active_0),
    .loss_o   (loss_0)
  );

  lane_loss_mon #(.LOSS_LIMIT(LOSS_LIMIT)) u_loss_1 (
    .clk_i    (clk_4f),
    .rst_i    (reset),
    .run_i    (link_run),
    .active_i (active_1),
    .loss_o   (loss_1)
  );

  // Next-state, counter and registered-output logic; !enable overrides all transitions.
  always_comb begin
    state_d       = state_q;
    tmo_cnt_d     = '0;
    skew_cnt_d    = skew_cnt_q;
    lag_lane_d    = lag_lane_q;
    skew_lane_d   = skew_lane_q;
    skew_cycles_d = skew_cycles_q;
    timeout_d     = 1'b0;
    retrain_d     = retrain_q;
    lead_act      = lag_lane_q ? active_0 : active_1;
    lag_act       = lag_lane_q ? active_1 : active_0;

    if (!enable) begin
      state_d    = ST_IDLE;
      skew_cnt_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          skew_cnt_d = '0;
          state_d    = ST_WAIT_FIRST;
        end
        ST_WAIT_FIRST: begin
          skew_cnt_d = '0;
          if (active_0 && active_1) begin
            state_d       = ST_LINK_UP;
            skew_lane_d   = 1'b0;
            skew_cycles_d = '0;
          end else if (active_0 || active_1) begin
            state_d    = ST_WAIT_SECOND;
            lag_lane_d = active_0;
            skew_cnt_d = SW'(1);
          end else if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_d   = ST_RECOVER;
            timeout_d = 1'b1;
          end else begin
            tmo_cnt_d = tmo_cnt_q + TW'(1);
          end
        end
        ST_WAIT_SECOND: begin
          if (!lead_act) begin
            state_d    = ST_WAIT_FIRST;
            skew_cnt_d = '0;
          end else if (lag_act) begin
            state_d       = ST_LINK_UP;
            skew_lane_d   = lag_lane_q;
            skew_cycles_d = 3'(skew_cnt_q);
          end else if (skew_cnt_q >= SW'(MAX_SKEW)) begin
            state_d = ST_RECOVER;
          end else begin
            skew_cnt_d = skew_cnt_q + SW'(1);
          end
        end
        ST_LINK_UP: begin
          if (loss_0 || loss_1) begin
            state_d = ST_RECOVER;
          end
        end
        ST_RECOVER: begin
          state_d = ST_WAIT_FIRST;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    if (state_d == ST_IDLE) begin
      skew_lane_d   = 1'b0;
      skew_cycles_d = '0;
    end

    if (state_d == ST_RECOVER && state_q != ST_RECOVER && retrain_q != '1) begin
      retrain_d = retrain_q + RETRAIN_WIDTH'(1);
    end

    link_up_d = (state_d == ST_LINK_UP);
    lane_en_d = {2{link_up_d}};
  end

  // State, counters and output registers.
  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      tmo_cnt_q     <= '0;
      skew_cnt_q    <= '0;
      lag_lane_q    <= 1'b0;
      link_up_q     <= 1'b0;
      lane_en_q     <= '0;
      skew_lane_q   <= 1'b0;
      skew_cycles_q <= '0;
      timeout_q     <= 1'b0;
      retrain_q     <= '0;
    end else begin
      state_q       <= state_d;
      tmo_cnt_q     <= tmo_cnt_d;
      skew_cnt_q    <= skew_cnt_d;
      lag_lane_q    <= lag_lane_d;
      link_up_q     <= link_up_d;
      lane_en_q     <= lane_en_d;
      skew_lane_q   <= skew_lane_d;
      skew_cycles_q <= skew_cycles_d;
      timeout_q     <= timeout_d;
      retrain_q     <= retrain_d;
    end
  end

  assign link_up     = link_up_q;
  assign lane_en     = lane_en_q;
  assign skew_lane   = skew_lane_q;
  assign skew_cycles = skew_cycles_q;
  assign timeout_err = timeout_q;
  assign retrain_cnt = retrain_q;
  assign state       = state_q;

endmodule

// File: tb/tb_phy_rx_link_ctrl.sv
// Directed bench for phy_rx_link_ctrl: expected output vectors are queued as
// each step is driven and checked after the following clock edge.
module tb_phy_rx_link_ctrl;

  logic       clk_4f = 1'b0;
  logic       reset;
  logic       enable;
  logic       active_0;
  logic       active_1;
  logic       link_up;
  logic [1:0] lane_en;
  logic       skew_lane;
  logic [2:0] skew_cycles;
  logic       timeout_err;
  logic [3:0] retrain_cnt;
  logic [2:0] state;

  typedef struct {
    string       tag;
    logic [14:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   rc    = 0;

  phy_rx_link_ctrl #(
    .TIMEOUT_CYCLES(64),
    .MAX_SKEW      (4),
    .LOSS_LIMIT    (3)
  ) dut (
    .clk_4f      (clk_4f),
    .reset       (reset),
    .enable      (enable),
    .active_0    (active_0),
    .active_1    (active_1),
    .link_up     (link_up),
    .lane_en     (lane_en),
    .skew_lane   (skew_lane),
    .skew_cycles (skew_cycles),
    .timeout_err (timeout_err),
    .retrain_cnt (retrain_cnt),
    .state       (state)
  );

  always #5 clk_4f = ~clk_4f;

  // {state, link_up, lane_en, skew_lane, skew_cycles, timeout_err, retrain_cnt}
  function automatic logic [14:0] pack(input logic [2:0] st, input logic lu, input logic skl,
                                       input logic [2:0] skc, input logic te, input int r);
    logic [3:0] r4;
    r4 = r[3:0];
    return {st, lu, {lu, lu}, skl, skc, te, r4};
  endfunction

  task automatic compare();
    exp_t        e;
    logic [14:0] obs;
    obs = {state, link_up, lane_en, skew_lane, skew_cycles, timeout_err, retrain_cnt};
    if (sb.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_empty observed=%h expected=entry", obs);
    end else begin
      e = sb.pop_front();
      n_vec++;
      assert (obs === e.exp)
      else begin
        n_err++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic expect_now(input string tag, input logic [2:0] st, input logic lu, input logic skl,
                            input logic [2:0] skc, input logic te, input int r);
    sb.push_back('{tag: tag, exp: pack(st, lu, skl, skc, te, r)});
    compare();
  endtask

  // Drive lane status, queue the result expected after the next edge, then check it.
  task automatic cyc(input logic a0, input logic a1, input string tag, input logic [2:0] st,
                     input logic lu, input logic skl, input logic [2:0] skc, input logic te,
                     input int r);
    active_0 = a0;
    active_1 = a1;
    sb.push_back('{tag: tag, exp: pack(st, lu, skl, skc, te, r)});
    @(posedge clk_4f);
    #1;
    compare();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset    = 1'b1;
    enable   = 1'b0;
    active_0 = 1'b0;
    active_1 = 1'b0;
    repeat (2) @(posedge clk_4f);
    #1;
    expect_now("reset_state", 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 0);
    reset = 1'b0;

    // Both lanes lock in the same cycle: link_up one clock after the sample.
    enable = 1'b1;
    cyc(0, 0, "en_wait_first", 3'd1, 0, 0, 3'd0, 0, rc);
    repeat (3) cyc(0, 0, "wf_idle", 3'd1, 0, 0, 3'd0, 0, rc);
    cyc(1, 1, "both_link_up", 3'd3, 1, 0, 3'd0, 0, rc);
    cyc(1, 1, "link_hold", 3'd3, 1, 0, 3'd0, 0, rc);

    // Asynchronous reset in LINK_UP clears outputs without a clock edge.
    #2;
    reset = 1'b1;
    #1;
    expect_now("async_reset", 3'd0, 0, 0, 3'd0, 0, 0);
    @(posedge clk_4f);
    #1;
    expect_now("reset_held", 3'd0, 0, 0, 3'd0, 0, 0);
    reset = 1'b0;

    // Lane 0 leads by 3 cycles.
    cyc(0, 0, "wf_after_rst", 3'd1, 0, 0, 3'd0, 0, rc);
    cyc(1, 0, "lead0", 3'd2, 0, 0, 3'd0, 0, rc);
    cyc(1, 0, "skew2", 3'd2, 0, 0, 3'd0, 0, rc);
    cyc(1, 0, "skew3", 3'd2, 0, 0, 3'd0, 0, rc);
    cyc(1, 1, "skew3_link", 3'd3, 1, 1, 3'd3, 0, rc);

    // Two-cycle drop-out tolerated, three-cycle drop-out retrains.
    cyc(1, 0, "drop1", 3'd3, 1, 1, 3'd3, 0, rc);
    cyc(1, 0, "drop2", 3'd3, 1, 1, 3'd3, 0, rc);
    cyc(1, 1, "drop_cleared", 3'd3, 1, 1, 3'd3, 0, rc);
    cyc(1, 0, "loss1", 3'd3, 1, 1, 3'd3, 0, rc);
    cyc(1, 0, "loss2", 3'd3, 1, 1, 3'd3, 0, rc);
    rc = 1;
    cyc(1, 0, "loss3_recover", 3'd4, 0, 1, 3'd3, 0, rc);
    cyc(0, 0, "recover_1cyc", 3'd1, 0, 1, 3'd3, 0, rc);

    // Lane 1 leads and lane 0 never follows: RECOVER once skew would exceed 4.
    cyc(0, 1, "lead1", 3'd2, 0, 1, 3'd3, 0, rc);
    cyc(0, 1, "ns2", 3'd2, 0, 1, 3'd3, 0, rc);
    cyc(0, 1, "ns3", 3'd2, 0, 1, 3'd3, 0, rc);
    cyc(0, 1, "ns4", 3'd2, 0, 1, 3'd3, 0, rc);
    rc = 2;
    cyc(0, 1, "skew_exceed", 3'd4, 0, 1, 3'd3, 0, rc);
    cyc(0, 0, "skew_rec_wf", 3'd1, 0, 1, 3'd3, 0, rc);

    // Skew of exactly MAX_SKEW is accepted; lagging lane is 0.
    cyc(0, 1, "lead1b", 3'd2, 0, 1, 3'd3, 0, rc);
    cyc(0, 1, "s2", 3'd2, 0, 1, 3'd3, 0, rc);
    cyc(0, 1, "s3", 3'd2, 0, 1, 3'd3, 0, rc);
    cyc(0, 1, "s4", 3'd2, 0, 1, 3'd3, 0, rc);
    cyc(1, 1, "skew4_link", 3'd3, 1, 0, 3'd4, 0, rc);

    // Disable drops the link, clears skew, keeps retrain count.
    enable = 1'b0;
    cyc(1, 1, "disable", 3'd0, 0, 0, 3'd0, 0, rc);
    enable = 1'b1;
    cyc(0, 0, "reenable", 3'd1, 0, 0, 3'd0, 0, rc);

    // Leading lane drops before the other arrives: back to WAIT_FIRST.
    cyc(1, 0, "lead_again", 3'd2, 0, 0, 3'd0, 0, rc);
    cyc(0, 0, "lead_drop", 3'd1, 0, 0, 3'd0, 0, rc);

    // 64 idle cycles in WAIT_FIRST: single-cycle timeout pulse with RECOVER.
    for (int i = 0; i < 63; i++) begin
      cyc(0, 0, "tmo_wait", 3'd1, 0, 0, 3'd0, 0, rc);
    end
    rc = 3;
    cyc(0, 0, "timeout", 3'd4, 0, 0, 3'd0, 1, rc);
    cyc(0, 0, "timeout_end", 3'd1, 0, 0, 3'd0, 0, rc);

    // Repeated loss retrains: retrain_cnt saturates at 15.
    for (int i = 0; i < 14; i++) begin
      cyc(1, 1, "sat_link", 3'd3, 1, 0, 3'd0, 0, rc);
      cyc(0, 0, "sat_l1", 3'd3, 1, 0, 3'd0, 0, rc);
      cyc(0, 0, "sat_l2", 3'd3, 1, 0, 3'd0, 0, rc);
      if (rc < 15) rc = rc + 1;
      cyc(0, 0, "sat_recover", 3'd4, 0, 0, 3'd0, 0, rc);
      cyc(0, 0, "sat_wf", 3'd1, 0, 0, 3'd0, 0, rc);
    end

    enable = 1'b0;
    cyc(0, 0, "sat_disable", 3'd0, 0, 0, 3'd0, 0, 15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
